// File: rtl/uart_pkg.sv
// Shared constants, tick-divider helper and frame-state encoding for the
// loopback UART transmitter and receiver.
package uart_pkg;

    localparam int DEF_CLK_FREQ   = 16_000_000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;

    function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator; o_tick is high for the one clock
// on which the divider wraps.
module uart_baud_gen #(
    parameter int TICK_DIV = 104
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_loopback.sv
// 8E1 UART whose transmitter drives its own receiver through the internal
// net `serial`; used as a link self-test block.
module uart_loopback
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] TxData,
    output logic       busy,
    output logic [7:0] RxData,
    output logic       valid_rx,
    output logic       Parity_error,
    output logic       Stop_error
);

    localparam int            TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int            OW       = $clog2(OVERSAMPLE);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);

    logic          w_tick;
    logic          w_start;
    logic          serial;

    logic          r_transmit_d;
    frame_state_t  r_tx_state;
    logic [7:0]    r_tx_shift;
    logic          r_tx_parity;
    logic [OW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic          r_tx_line;

    frame_state_t  r_rx_state;
    logic [7:0]    r_rx_shift;
    logic          r_rx_parity;
    logic [OW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;

    uart_baud_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (reset),
        .o_tick (w_tick)
    );

    assign serial  = r_tx_line;
    assign w_start = transmit & ~r_transmit_d & ~busy;

    // Transmitter: latch on the start event, then advance the line only on ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_transmit_d <= 1'b0;
            busy         <= 1'b0;
            r_tx_state   <= IDLE;
            r_tx_shift   <= '0;
            r_tx_parity  <= 1'b0;
            r_tx_cnt     <= '0;
            r_tx_bit     <= '0;
            r_tx_line    <= 1'b1;
        end else begin
            r_transmit_d <= transmit;
            if (w_start) begin
                busy        <= 1'b1;
                r_tx_shift  <= TxData;
                r_tx_parity <= ^TxData;
            end else if (w_tick) begin
                if (r_tx_state != IDLE)
                    r_tx_cnt <= (r_tx_cnt == OS_LAST) ? '0 : r_tx_cnt + 1'b1;
                case (r_tx_state)
                    IDLE: if (busy) begin
                        r_tx_state <= START;
                        r_tx_line  <= 1'b0;
                        r_tx_cnt   <= '0;
                    end
                    START: if (r_tx_cnt == OS_LAST) begin
                        r_tx_state <= DATA;
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_bit   <= '0;
                    end
                    DATA: if (r_tx_cnt == OS_LAST) begin
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= PARITY;
                            r_tx_line  <= r_tx_parity;
                        end else begin
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_line  <= r_tx_shift[1];
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end
                    PARITY: if (r_tx_cnt == OS_LAST) begin
                        r_tx_state <= STOP;
                        r_tx_line  <= 1'b1;
                    end
                    STOP: if (r_tx_cnt == OS_LAST) begin
                        r_tx_state <= IDLE;
                        busy       <= 1'b0;
                    end
                    default: r_tx_state <= IDLE;
                endcase
            end
        end
    end

    // Receiver: mid-bit sampling, 8 ticks after the start edge then every 16.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state   <= IDLE;
            r_rx_shift   <= '0;
            r_rx_parity  <= 1'b0;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            RxData       <= '0;
            valid_rx     <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
        end else begin
            valid_rx <= 1'b0;
            if (w_tick) begin
                case (r_rx_state)
                    IDLE: if (!serial) begin
                        r_rx_state <= START;
                        r_rx_cnt   <= '0;
                    end
                    START: if (r_rx_cnt == OS_MID) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= serial ? IDLE : DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                    DATA: if (r_rx_cnt == OS_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {serial, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= PARITY;
                        else
                            r_rx_bit <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                    PARITY: if (r_rx_cnt == OS_LAST) begin
                        r_rx_cnt    <= '0;
                        r_rx_parity <= serial;
                        r_rx_state  <= STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                    STOP: if (r_rx_cnt == OS_LAST) begin
                        r_rx_cnt     <= '0;
                        RxData       <= r_rx_shift;
                        Parity_error <= (^r_rx_shift) != r_rx_parity;
                        Stop_error   <= ~serial;
                        valid_rx     <= 1'b1;
                        r_rx_state   <= IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                    default: r_rx_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loopback.sv
// Directed bench for uart_loopback, run at a reduced clock so one bit is
// 128 clocks (8 clocks per oversample tick).
module tb_uart_loopback;

    localparam int CLK_FREQ   = 1_228_800;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = 16;
    localparam int TICK       = 8;
    localparam int BIT        = TICK * OVERSAMPLE;
    localparam int FRAME      = 11 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       transmit = 1'b0;
    logic [7:0] TxData = 8'h00;
    logic       busy;
    logic [7:0] RxData;
    logic       valid_rx;
    logic       Parity_error;
    logic       Stop_error;

    uart_loopback #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .transmit     (transmit),
        .TxData       (TxData),
        .busy         (busy),
        .RxData       (RxData),
        .valid_rx     (valid_rx),
        .Parity_error (Parity_error),
        .Stop_error   (Stop_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int busy_cnt = 0;
    int valid_base;
    int busy_base;

    always @(negedge clk) begin
        if (valid_rx === 1'b1) valid_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        int         hold;
        logic [7:0] exp_rx;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic start_frame(input logic [7:0] d, input int hold);
        @(negedge clk);
        valid_base = valid_cnt;
        busy_base  = busy_cnt;
        TxData     = d;
        transmit   = 1'b1;
        repeat (hold) @(negedge clk);
        transmit = 1'b0;
    endtask

    task automatic wait_start_bit(input string name);
        int n = 0;
        while (dut.serial !== 1'b0 && n < 4 * BIT) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s start_bit_seen", name), dut.serial, 1'b0);
    endtask

    task automatic finish_frame(input string name, input logic [7:0] exp_rx,
                                input logic exp_perr, input logic exp_serr);
        int n = 0;
        while (busy === 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s busy_drop", name), busy, 1'b0);
        repeat (4) @(negedge clk);
        check_range($sformatf("%s busy_len", name), busy_cnt - busy_base, FRAME, FRAME + TICK + 1);
        check($sformatf("%s valid_pulses", name), valid_cnt - valid_base, 1);
        check($sformatf("%s rx_data", name), RxData, exp_rx);
        check($sformatf("%s parity_err", name), Parity_error, exp_perr);
        check($sformatf("%s stop_err", name), Stop_error, exp_serr);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA3, hold: 640, exp_rx: 8'hA3, exp_perr: 1'b0, exp_serr: 1'b0};
        vecs[1] = '{data: 8'h01, hold: 1,   exp_rx: 8'h01, exp_perr: 1'b0, exp_serr: 1'b0};
        vecs[2] = '{data: 8'hFF, hold: 1,   exp_rx: 8'hFF, exp_perr: 1'b0, exp_serr: 1'b0};
        vecs[3] = '{data: 8'h00, hold: 1,   exp_rx: 8'h00, exp_perr: 1'b0, exp_serr: 1'b0};

        // Reset held for 640 clocks, outputs idle throughout and after.
        #2 reset = 1'b0;
        repeat (320) @(negedge clk);
        check("reset_mid busy", busy, 1'b0);
        check("reset_mid serial", dut.serial, 1'b1);
        repeat (320) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset valid", valid_rx, 1'b0);
        check("reset rx_data", RxData, 8'h00);
        check("reset parity_err", Parity_error, 1'b0);
        check("reset stop_err", Stop_error, 1'b0);
        reset = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("idle valid_pulses", valid_cnt, 0);
        check("idle busy", busy, 1'b0);
        check("idle serial", dut.serial, 1'b1);

        // Table: long-held transmit, then back-to-back frames.
        for (int i = 0; i < 4; i++) begin
            start_frame(vecs[i].data, vecs[i].hold);
            finish_frame($sformatf("vec%0d", i), vecs[i].exp_rx, vecs[i].exp_perr, vecs[i].exp_serr);
        end

        // Second edge and TxData change mid-frame are ignored.
        start_frame(8'h96, 1);
        wait_start_bit("ignore");
        repeat (3 * BIT) @(negedge clk);
        TxData   = 8'h5C;
        transmit = 1'b1;
        repeat (4) @(negedge clk);
        transmit = 1'b0;
        repeat (BIT) @(negedge clk);
        TxData = 8'h3A;
        finish_frame("ignore", 8'h96, 1'b0, 1'b0);

        // Inverted parity bit (0xA5 has even parity, bit 0 -> forced 1).
        start_frame(8'hA5, 1);
        wait_start_bit("perr");
        repeat (9 * BIT + BIT / 4) @(negedge clk);
        force dut.serial = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        release dut.serial;
        finish_frame("perr", 8'hA5, 1'b1, 1'b0);

        // Stop bit forced low.
        start_frame(8'h3C, 1);
        wait_start_bit("serr");
        repeat (10 * BIT + BIT / 4) @(negedge clk);
        force dut.serial = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        release dut.serial;
        finish_frame("serr", 8'h3C, 1'b0, 1'b1);
        repeat (BIT) @(negedge clk);
        check("serr hold stop_err", Stop_error, 1'b1);
        check("serr hold rx_data", RxData, 8'h3C);

        // Reset in the middle of a data bit aborts the frame.
        start_frame(8'h77, 1);
        wait_start_bit("abort");
        repeat (3 * BIT + BIT / 2) @(negedge clk);
        valid_base = valid_cnt;
        reset = 1'b0;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort serial", dut.serial, 1'b1);
        check("abort rx_data", RxData, 8'h00);
        check("abort stop_err", Stop_error, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        check("abort valid_pulses", valid_cnt - valid_base, 0);
        check("abort busy_after", busy, 1'b0);

        start_frame(8'h55, 1);
        finish_frame("post_abort", 8'h55, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_loopback.md
Name: uart_loopback

Overview:
- Self-contained 8-bit UART with internal serial loopback: the transmitter output line drives the receiver input directly.
- Used as a link self-test block: the host loads a byte, pulses transmit, and reads back the received byte with frame-error status.
- Frame format: 1 start (0), 8 data bits LSB first, 1 even-parity bit, 1 stop (1); 11 bits per frame.

Parameters:
- CLK_FREQ, 16000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, receiver ticks per bit.
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) = 104, clocks per oversample tick.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-low reset.
- transmit  in  1  start request; rising edge starts a frame.
- TxData  in  8  byte to send; latched at frame start.
- busy  out  1  high while a frame is being transmitted.
- RxData  out  8  last received byte.
- valid_rx  out  1  one-clock pulse when a frame has been received.
- Parity_error  out  1  parity status of the last received frame.
- Stop_error  out  1  stop-bit status of the last received frame.

Behaviour:
- Reset (reset=0, async): busy=0, RxData=0x00, valid_rx=0, Parity_error=0, Stop_error=0, internal serial line=1 (idle), all FSMs go to IDLE, tick counter=0.
- Tick generator: free-running counter 0..TICK_DIV-1; a one-clock tick fires on wrap. Shared by TX and RX.
- transmit is registered each clock. A start event is transmit=1 with the previous sample=0 and busy=0.
- On a start event, the next clock: busy=1 and TxData is copied to the shift register with computed parity (XOR of the 8 bits).
- Holding transmit high does not start another frame.
- Edges while busy=1 are ignored. TxData changes after latching are ignored.
- TX FSM: IDLE -> START -> DATA(8 bits) -> PARITY -> STOP -> IDLE. Line changes only on a tick. START begins on the first tick after latching. Each state or bit lasts exactly OVERSAMPLE ticks (1664 clocks).
- busy drops to 0 on the clock the STOP bit's 16th tick completes. Frame duration is 11*1664 clocks, +0..1 tick of start alignment.
- RX FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE, clocked on ticks.
  - IDLE: a line=0 sample moves to START.
  - START: at tick 8 (mid-bit), line=1 means a false start; return to IDLE with no output.
  - Every 16 ticks after mid-start, sample one bit: data LSB first into the shift register, then parity, then stop.
- At the stop-bit sample, on the same clock:
  - RxData = received byte.
  - Parity_error = (XOR of data bits) != parity bit.
  - Stop_error = (stop sample == 0).
  - valid_rx = 1 for exactly one clock. It pulses even if an error flag is set.
  - RX returns to IDLE, ready for the next start edge.
- RxData and the error flags hold until the next frame completes or reset.
- The receiver runs independently of busy. valid_rx occurs ~0.5 bit before busy falls.
- Reset mid-frame: everything clears immediately, no valid_rx for the aborted frame, and the line returns to idle.
- The internal serial net is named `serial` so benches can force it for error injection.

Decomposition:
- Package uart_pkg: CLK_FREQ/BAUD/OVERSAMPLE defaults, TICK_DIV function, frame-state enum (IDLE, START, DATA, PARITY, STOP) shared by TX and RX.
- One natural sub-module: uart_baud_gen (tick generator). TX and RX FSMs stay inline in uart_loopback.

Test Plan:
- Reset held low for 640 clocks, then released -> busy=0, valid_rx=0, RxData=0x00, both error flags 0 throughout.
- TxData=0xA3, transmit held high for 640 clocks then low:
  - busy=1 for ~18304 clocks (±104).
  - exactly one valid_rx pulse.
  - RxData=0xA3, Parity_error=0, Stop_error=0.
- Back-to-back frames 0x01 (parity bit 1), 0xFF (parity bit 0), 0x00 -> each yields a single valid_rx with the matching RxData and no errors.
- Second transmit edge mid-frame with TxData=0x5C -> ignored; only the first byte is received and busy stays continuous.
- Force `serial` inverted during the parity bit -> Parity_error=1. Force `serial`=0 during the stop bit -> Stop_error=1. valid_rx still pulses in both cases.
- reset asserted mid-data-bit:
  - busy=0 immediately and no valid_rx.
  - a following 0x55 frame is received correctly.
